// File: rtl/matrix_operand_sequencer_if.sv
// matrix_operand_sequencer_if: load stream in, operand-pair stream out, plus enable and done.
interface matrix_operand_sequencer_if #(
    parameter int N          = 4,
    parameter int DATA_WIDTH = 64
);
    localparam int IW = $clog2(N);
    logic                  clk_enable;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  ce_out;
    logic [DATA_WIDTH-1:0] Out1;
    logic [DATA_WIDTH-1:0] Out2;
    logic                  out_valid;
    logic                  out_first;
    logic                  out_last;
    logic [IW-1:0]         out_row;
    logic [IW-1:0]         out_col;
    logic                  done;
    modport master (
        output clk_enable, in_valid, in_data,
        input  in_ready, ce_out, Out1, Out2, out_valid, out_first, out_last, out_row, out_col, done
    );
    modport slave (
        input  clk_enable, in_valid, in_data,
        output in_ready, ce_out, Out1, Out2, out_valid, out_first, out_last, out_row, out_col, done
    );
endinterface

// File: rtl/matrix_operand_sequencer.sv
// matrix_operand_sequencer: buffers NxN matrices A and B from a row-major load stream and
// replays every A[i][k]/B[k][j] pair in i,j,k order with framing for a dot-product accumulator.
module matrix_operand_sequencer #(
    parameter int N          = 4,
    parameter int DATA_WIDTH = 64
) (
    input logic                       clk,
    input logic                       reset,
    matrix_operand_sequencer_if.slave bus
);
    localparam int IW = $clog2(N);
    localparam int NN = N * N;
    localparam int CW = $clog2(NN);

    typedef enum logic [1:0] {LOAD_A, LOAD_B, ISSUE, DONE} state_t;

    state_t                state_q;
    logic [CW-1:0]         cnt_q;
    logic [IW-1:0]         i_q, j_q, k_q;
    logic [DATA_WIDTH-1:0] a_mem [NN];
    logic [DATA_WIDTH-1:0] b_mem [NN];
    logic [DATA_WIDTH-1:0] out1_q, out2_q;
    logic                  valid_q, first_q, last_q, done_q;
    logic [IW-1:0]         row_q, col_q;
    logic                  accept, cnt_last, k_end, j_end, i_end;
    logic [CW-1:0]         a_addr, b_addr;

    assign bus.ce_out   = bus.clk_enable;
    assign bus.in_ready = bus.clk_enable && (state_q == LOAD_A || state_q == LOAD_B);
    assign accept       = bus.in_ready && bus.in_valid;
    assign cnt_last     = cnt_q == CW'(NN - 1);
    assign k_end        = k_q == IW'(N - 1);
    assign j_end        = j_q == IW'(N - 1);
    assign i_end        = i_q == IW'(N - 1);
    assign a_addr       = CW'(int'(i_q) * N + int'(k_q));
    assign b_addr       = CW'(int'(k_q) * N + int'(j_q));

    // Operand storage is deliberately left unreset; a new load always overwrites it fully.
    always_ff @(posedge clk) begin
        if (accept && state_q == LOAD_A) a_mem[cnt_q] <= bus.in_data;
        if (accept && state_q == LOAD_B) b_mem[cnt_q] <= bus.in_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= LOAD_A;
            cnt_q   <= '0;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            out1_q  <= '0;
            out2_q  <= '0;
            valid_q <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            row_q   <= '0;
            col_q   <= '0;
            done_q  <= 1'b0;
        end else if (bus.clk_enable) begin
            done_q <= 1'b0;
            case (state_q)
                LOAD_A, LOAD_B: if (bus.in_valid) begin
                    cnt_q <= cnt_last ? '0 : cnt_q + 1'b1;
                    if (cnt_last) state_q <= (state_q == LOAD_A) ? LOAD_B : ISSUE;
                end
                ISSUE: begin
                    out1_q  <= a_mem[a_addr];
                    out2_q  <= b_mem[b_addr];
                    valid_q <= 1'b1;
                    first_q <= k_q == '0;
                    last_q  <= k_end;
                    row_q   <= i_q;
                    col_q   <= j_q;
                    // k innermost, then j, then i; the final pair hands over to DONE
                    k_q <= k_end ? '0 : k_q + 1'b1;
                    if (k_end) j_q <= j_end ? '0 : j_q + 1'b1;
                    if (k_end && j_end) i_q <= i_end ? '0 : i_q + 1'b1;
                    if (k_end && j_end && i_end) state_q <= DONE;
                end
                default: begin
                    valid_q <= 1'b0;
                    first_q <= 1'b0;
                    last_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= LOAD_A;
                end
            endcase
        end
    end

    assign bus.Out1      = out1_q;
    assign bus.Out2      = out2_q;
    assign bus.out_valid = valid_q;
    assign bus.out_first = first_q;
    assign bus.out_last  = last_q;
    assign bus.out_row   = row_q;
    assign bus.out_col   = col_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_matrix_operand_sequencer.sv
// tb_matrix_operand_sequencer: directed loads into N=2 and N=4 sequencers, checked every cycle
// against a queue model of the expected pair stream, plus hand-computed literal expectations.
module tb_matrix_operand_sequencer;
    typedef struct packed {logic [63:0] a, b; logic f, l; logic [3:0] r, c;} pair_t;
    typedef struct {logic [63:0] a, b; logic f; int r, c, cyc;} ent_t;
    localparam logic [63:0] NAN = 64'h7FF8_0000_0000_0001;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int asrt = 0;
    int fails = 0;
    int nn [2] = '{2, 4};
    logic [63:0] wq [2][$];
    pair_t pq [2][$];
    pair_t ex [2];
    logic exv [2], exd [2], cee [2];
    int ph [2], ecyc [2];
    ent_t log0 [$];
    int dlog0 [$];
    int cnt1 = 0, nan1 = 0, dcnt1 = 0;
    logic [63:0] dv [9];

    always #5 clk = ~clk;

    matrix_operand_sequencer_if #(.N(2), .DATA_WIDTH(64)) b0 ();
    matrix_operand_sequencer_if #(.N(4), .DATA_WIDTH(64)) b1 ();
    matrix_operand_sequencer #(.N(2), .DATA_WIDTH(64)) dut0 (.clk(clk), .reset(reset), .bus(b0));
    matrix_operand_sequencer #(.N(4), .DATA_WIDTH(64)) dut1 (.clk(clk), .reset(reset), .bus(b1));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        asrt++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Expected stream: every (i,j,k) pair computed directly from the loaded matrices.
    task automatic build(input int m);
        int n = nn[m];
        for (int i = 0; i < n; i++)
            for (int j = 0; j < n; j++)
                for (int k = 0; k < n; k++) begin
                    pair_t p;
                    p.a = wq[m][i*n+k];
                    p.b = wq[m][n*n+k*n+j];
                    p.f = k == 0;
                    p.l = k == n - 1;
                    p.r = 4'(i);
                    p.c = 4'(j);
                    pq[m].push_back(p);
                end
        wq[m].delete();
    endtask

    task automatic cmp(input int m, input logic ce, ceo, ir, ov, of, ol, dn,
                       input logic [63:0] o1, o2, input logic [3:0] r, c);
        string p = (m == 0) ? "n2" : "n4";
        chk({p, ".ce_out"}, 64'(ceo), 64'(ce));
        chk({p, ".in_ready"}, 64'(ir), 64'(ce && ph[m] == 0));
        chk({p, ".out_valid"}, 64'(ov), 64'(exv[m]));
        chk({p, ".out_first"}, 64'(of), 64'(ex[m].f));
        chk({p, ".out_last"}, 64'(ol), 64'(ex[m].l));
        chk({p, ".done"}, 64'(dn), 64'(exd[m]));
        chk({p, ".Out1"}, o1, ex[m].a);
        chk({p, ".Out2"}, o2, ex[m].b);
        chk({p, ".out_row"}, 64'(r), 64'(ex[m].r));
        chk({p, ".out_col"}, 64'(c), 64'(ex[m].c));
    endtask

    // Inputs change only at negedge+1, so here they equal what the previous posedge sampled.
    always @(negedge clk) begin
        for (int m = 0; m < 2; m++) begin
            logic ce, iv;
            logic [63:0] id;
            ce = (m == 0) ? b0.clk_enable : b1.clk_enable;
            iv = (m == 0) ? b0.in_valid : b1.in_valid;
            id = (m == 0) ? b0.in_data : b1.in_data;
            if (!reset) begin
                wq[m].delete();
                pq[m].delete();
                ph[m] = 0;
                ex[m] = '0;
                exv[m] = 1'b0;
                exd[m] = 1'b0;
                cee[m] = 1'b0;
            end else begin
                cee[m] = ce;
                if (ce) begin
                    ecyc[m]++;
                    if (ph[m] == 0) begin
                        exv[m] = 1'b0;
                        exd[m] = 1'b0;
                        ex[m].f = 1'b0;
                        ex[m].l = 1'b0;
                        if (iv) begin
                            wq[m].push_back(id);
                            if (wq[m].size() == 2 * nn[m] * nn[m]) begin
                                build(m);
                                ph[m] = 1;
                            end
                        end
                    end else if (ph[m] == 1) begin
                        ex[m] = pq[m].pop_front();
                        exv[m] = 1'b1;
                        exd[m] = 1'b0;
                        if (pq[m].size() == 0) ph[m] = 2;
                    end else begin
                        exv[m] = 1'b0;
                        exd[m] = 1'b1;
                        ex[m].f = 1'b0;
                        ex[m].l = 1'b0;
                        ph[m] = 0;
                    end
                end
            end
        end
        cmp(0, b0.clk_enable, b0.ce_out, b0.in_ready, b0.out_valid, b0.out_first, b0.out_last,
            b0.done, b0.Out1, b0.Out2, 4'(b0.out_row), 4'(b0.out_col));
        cmp(1, b1.clk_enable, b1.ce_out, b1.in_ready, b1.out_valid, b1.out_first, b1.out_last,
            b1.done, b1.Out1, b1.Out2, 4'(b1.out_row), 4'(b1.out_col));
        if (reset && cee[0] && b0.out_valid)
            log0.push_back('{b0.Out1, b0.Out2, b0.out_first, int'(b0.out_row), int'(b0.out_col), ecyc[0]});
        if (reset && cee[0] && b0.done) dlog0.push_back(ecyc[0]);
        if (reset && cee[1] && b1.out_valid) begin
            cnt1++;
            if (b1.Out2 === NAN) nan1++;
        end
        if (reset && cee[1] && b1.done) dcnt1++;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic set_in(input int m, input logic v, input logic [63:0] d);
        if (m == 0) begin
            b0.in_valid = v;
            b0.in_data = d;
        end else begin
            b1.in_valid = v;
            b1.in_data = d;
        end
    endtask

    task automatic load(input int m, input logic [63:0] w[$], input bit gap);
        foreach (w[x]) begin
            int t = 0;
            logic acc;
            set_in(m, 1'b1, w[x]);
            #1;
            do begin
                acc = (m == 0) ? (b0.in_ready && b0.in_valid) : (b1.in_ready && b1.in_valid);
                step();
                t++;
            end while (!acc && t < 200);
            chk("load_accept", 64'(acc), 64'd1);
            if (gap) begin
                set_in(m, 1'b0, '0);
                step();
            end
        end
        set_in(m, 1'b0, '0);
    endtask

    task automatic wait_done(input int m, input int target);
        int t = 0;
        while (((m == 0) ? dlog0.size() : dcnt1) < target && t < 1000) begin
            step();
            t++;
        end
        chk("done_seen", 64'(((m == 0) ? dlog0.size() : dcnt1) >= target), 64'd1);
    endtask

    task automatic wait_log(input int n);
        int t = 0;
        while (log0.size() < n && t < 1000) begin
            step();
            t++;
        end
        chk("pair_seen", 64'(log0.size() >= n), 64'd1);
    endtask

    // Hand-derived N=2 stream for A=[1,2;3,4], B=[5,6;7,8].
    task automatic check_lit(input int sz, input int di);
        int ai [8] = '{1, 2, 1, 2, 3, 4, 3, 4};
        int bi [8] = '{5, 7, 6, 8, 5, 7, 6, 8};
        int ri [8] = '{0, 0, 0, 0, 1, 1, 1, 1};
        int ci [8] = '{0, 0, 1, 1, 0, 0, 1, 1};
        chk("lit_count", 64'(log0.size()), 64'(sz));
        if (log0.size() >= 8) begin
            for (int x = 0; x < 8; x++) begin
                chk($sformatf("lit_a%0d", x), log0[x].a, dv[ai[x]]);
                chk($sformatf("lit_b%0d", x), log0[x].b, dv[bi[x]]);
                chk($sformatf("lit_row%0d", x), 64'(log0[x].r), 64'(ri[x]));
                chk($sformatf("lit_col%0d", x), 64'(log0[x].c), 64'(ci[x]));
                chk($sformatf("lit_first%0d", x), 64'(log0[x].f), 64'(x % 2 == 0));
            end
            if (dlog0.size() > di)
                chk("done_latency", 64'(dlog0[di] - log0[7].cyc), 64'd1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] m1 [$];
        logic [63:0] m2 [$];
        logic [63:0] m4 [$];
        int dbase;
        dv[0] = '0;
        dv[1] = 64'h3FF0_0000_0000_0000;
        dv[2] = 64'h4000_0000_0000_0000;
        dv[3] = 64'h4008_0000_0000_0000;
        dv[4] = 64'h4010_0000_0000_0000;
        dv[5] = 64'h4014_0000_0000_0000;
        dv[6] = 64'h4018_0000_0000_0000;
        dv[7] = 64'h401C_0000_0000_0000;
        dv[8] = 64'h4020_0000_0000_0000;
        for (int x = 1; x <= 8; x++) m1.push_back(dv[x]);
        for (int x = 0; x < 4; x++) m2.push_back({32'hDEAD_BEEF, 32'(x)});
        for (int x = 0; x < 4; x++) m2.push_back({32'hCAFE_F00D, 32'(x)});
        for (int x = 0; x < 16; x++) m4.push_back((x / 4 == x % 4) ? dv[1] : 64'd0);
        for (int x = 0; x < 16; x++) m4.push_back((x == 9) ? NAN : 64'(x + 1));
        b0.clk_enable = 1'b1;
        b1.clk_enable = 1'b1;
        set_in(0, 1'b0, '0);
        set_in(1, 1'b0, '0);
        repeat (3) step();
        chk("rst_out_valid", 64'(b0.out_valid), 64'd0);
        chk("rst_Out1", b0.Out1, 64'd0);
        chk("rst_done", 64'(b0.done), 64'd0);
        chk("rst_in_ready", 64'(b0.in_ready), 64'd1);
        reset = 1'b1;
        step();
        // Plain load, in_valid held high
        log0.delete();
        load(0, m1, 1'b0);
        wait_done(0, 1);
        check_lit(8, 0);
        // in_valid toggling every other cycle
        log0.delete();
        load(0, m1, 1'b1);
        wait_done(0, 2);
        check_lit(8, 1);
        // clk_enable low for 3 cycles while pair 3 is presented
        log0.delete();
        load(0, m1, 1'b0);
        wait_log(3);
        b0.clk_enable = 1'b0;
        #1;
        chk("freeze_ce_out", 64'(b0.ce_out), 64'd0);
        chk("freeze_in_ready", 64'(b0.in_ready), 64'd0);
        repeat (3) begin
            step();
            chk("freeze_valid", 64'(b0.out_valid), 64'd1);
            chk("freeze_Out1", b0.Out1, dv[1]);
            chk("freeze_Out2", b0.Out2, dv[6]);
        end
        b0.clk_enable = 1'b1;
        wait_done(0, 3);
        check_lit(8, 2);
        // Async reset while pair 5 is presented, then a fresh load
        log0.delete();
        load(0, m1, 1'b0);
        wait_log(5);
        reset = 1'b0;
        #1;
        chk("arst_Out1", b0.Out1, 64'd0);
        chk("arst_Out2", b0.Out2, 64'd0);
        chk("arst_valid", 64'(b0.out_valid), 64'd0);
        chk("arst_first", 64'(b0.out_first), 64'd0);
        chk("arst_row", 64'(b0.out_row), 64'd0);
        chk("arst_col", 64'(b0.out_col), 64'd0);
        chk("arst_done", 64'(b0.done), 64'd0);
        step();
        reset = 1'b1;
        #1;
        chk("arst_in_ready", 64'(b0.in_ready), 64'd1);
        log0.delete();
        load(0, m1, 1'b0);
        wait_done(0, 4);
        check_lit(8, 3);
        // Two matrix sets back to back
        log0.delete();
        dbase = dlog0.size();
        load(0, m1, 1'b0);
        load(0, m2, 1'b0);
        wait_done(0, dbase + 2);
        check_lit(16, dbase);
        if (log0.size() >= 16 && dlog0.size() > dbase) begin
            chk("b2b_latency", 64'(log0[8].cyc - dlog0[dbase]), 64'd9);
            chk("b2b_a0", log0[8].a, m2[0]);
            chk("b2b_b0", log0[8].b, m2[4]);
            chk("b2b_a15", log0[15].a, m2[3]);
            chk("b2b_b15", log0[15].b, m2[7]);
        end
        // N=4 identity times B with a NaN element
        load(1, m4, 1'b0);
        wait_done(1, 1);
        chk("n4_pairs", 64'(cnt1), 64'd64);
        chk("n4_nan_pairs", 64'(nan1), 64'd4);
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", asrt, fails);
        $finish;
    end
endmodule

// File: doc/matrix_operand_sequencer.md
Name: matrix_operand_sequencer

Overview:
- Upstream feeder for the double-precision matrix multiply stage.
- Buffers one N×N matrix A and one N×N matrix B, both loaded as a row-major stream of IEEE-754 doubles.
- Then issues every operand pair A[i][k], B[k][j] in dot-product order, one pair per enabled cycle, on Out1/Out2 (which drive the multiply stage's In1/In2).
- Framing flags (first/last/row/col) let a downstream accumulator form C[i][j].

Parameters:
- N, 4, matrix dimension; legal range 2..16.
- DATA_WIDTH, 64, element width; double-precision bit pattern, passed through untouched.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- clk_enable  input  1  global enable; when low, all state holds.
- in_valid  input  1  load word present.
- in_ready  output  1  load word accepted when in_valid & in_ready.
- in_data  input  DATA_WIDTH  load word; A row-major first, then B row-major.
- ce_out  output  1  equals clk_enable, combinational.
- Out1  output  DATA_WIDTH  operand A[i][k].
- Out2  output  DATA_WIDTH  operand B[k][j].
- out_valid  output  1  Out1/Out2 pair is valid.
- out_first  output  1  pair has k==0.
- out_last  output  1  pair has k==N-1.
- out_row  output  IW  i index, where IW = clog2(N).
- out_col  output  IW  j index.
- done  output  1  one-cycle pulse after the final pair.

Behaviour:
- Reset (asserted low, async):
  - State goes to LOAD_A; load count, i, j, k go to 0.
  - Out1, Out2, out_valid, out_first, out_last, out_row, out_col, done all go to 0.
  - Buffer storage is not reset.
  - Reset mid-operation abandons the current matrices.
- clk_enable low: no register updates; registered outputs hold, including out_valid=1 if it was set. in_ready is forced to 0.
- in_ready = clk_enable & (state==LOAD_A or state==LOAD_B), combinational. in_data is ignored in all other states.
- LOAD_A:
  - Each accepted word is written to A[cnt/N][cnt%N] and cnt increments.
  - On acceptance with cnt==N*N-1: cnt goes to 0 and state goes to LOAD_B.
- LOAD_B:
  - Each accepted word is written to B[cnt/N][cnt%N] in the same way.
  - On acceptance of the last word: state goes to ISSUE.
- ISSUE, on each enabled edge:
  - Registers Out1=A[i][k], Out2=B[k][j], out_valid=1, out_first=(k==0), out_last=(k==N-1), out_row=i, out_col=j.
  - Advances k first, then j, then i, with wrap to 0.
  - Emission order is i outer, j middle, k inner; there are exactly N³ pairs.
  - The edge that emits i=j=k=N-1 moves state to DONE.
- DONE, on an enabled edge:
  - out_valid=0, out_first=0, out_last=0, done=1.
  - State goes to LOAD_A.
- done is cleared on the next enabled edge.
- Out1/Out2/out_row/out_col hold their last values while out_valid=0.
- Latency:
  - First pair appears one enabled edge after the edge accepting the last B word.
  - Pairs are back-to-back with no bubbles while clk_enable stays high.
  - Stream takes N³ enabled cycles; done appears on the next enabled edge.
- Back-to-back: in_ready is 1 in the cycle after done goes high, so a new load can start immediately.
- No arithmetic is performed on data; values are copied bit-exact, including NaN/Inf/denormals.

Test Plan:
- N=2, load A=[1,2;3,4] and B=[5,6;7,8] (0x3FF0…, 0x4000…, 0x4008…, 0x4010…, 0x4014…, 0x4018…, 0x401C…, 0x4020…) with in_valid held high:
  - Pairs must be (1,5),(2,7),(1,6),(2,8),(3,5),(4,7),(3,6),(4,8).
  - first/last must alternate 10,01.
  - row/col must be 00,00,01,01,10,10,11,11.
  - done must pulse one cycle after the 8th pair.
- Same load with in_valid toggling every other cycle: stored data and output stream identical; in_ready=0 throughout ISSUE.
- clk_enable dropped for 3 cycles during the 3rd pair: Out1/Out2/out_valid frozen, ce_out=0, in_ready=0; stream resumes at pair 4 with no pair lost or duplicated.
- Reset asserted during the 5th pair: all outputs 0 immediately (async); after release in_ready=1 in LOAD_A, and a fresh load produces a correct full stream.
- Two consecutive matrix sets loaded right after done: the second stream starts 2N²+1 enabled cycles after the first done and reflects only the new data.
- N=4, A=identity, B elements 0x0000000000000001..0x10 plus one NaN (0x7FF8000000000001): 64 pairs emitted; Out2 values bit-exact, including the NaN.
